// File: rtl/mapper_mem_arbiter.sv
// Cartridge memory port arbiter: shares one req/ack memory port between CPU (via mapper),
// ROM loader and SRAM backup DMA, one transaction at a time, with hung-access timeout.
module mapper_mem_arbiter #(
  parameter int unsigned ADDR_W  = 27,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rnw,
  input  logic              cpu_sram,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_wait,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [7:0]        ld_wdata,
  output logic              ld_ack,
  input  logic              bk_req,
  input  logic [ADDR_W-1:0] bk_addr,
  input  logic              bk_rnw,
  input  logic [7:0]        bk_wdata,
  output logic [7:0]        bk_rdata,
  output logic              bk_ack,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rnw,
  output logic              mem_sram,
  output logic [7:0]        mem_wdata,
  input  logic              mem_ack,
  input  logic [7:0]        mem_rdata,
  output logic              err_overrun,
  output logic              err_timeout
);

  localparam int unsigned      CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;
  typedef enum logic [1:0] {OWN_CPU, OWN_LD, OWN_BK} owner_t;

  state_t            r_state, w_state_nxt;
  owner_t            r_owner, w_owner_nxt;
  owner_t            r_last, w_last_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;

  logic              r_cpu_pend;
  logic [ADDR_W-1:0] r_cpu_addr;
  logic              r_cpu_rnw;
  logic              r_cpu_sram;
  logic [7:0]        r_cpu_wdata;
  logic              r_err_overrun;

  logic              r_mem_req, w_mem_req_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_nxt;
  logic              r_mem_rnw, w_mem_rnw_nxt;
  logic              r_mem_sram, w_mem_sram_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic [7:0]        r_cpu_rdata, w_cpu_rdata_nxt;
  logic [7:0]        r_bk_rdata, w_bk_rdata_nxt;
  logic              r_ld_ack, w_ld_ack_nxt;
  logic              r_bk_ack, w_bk_ack_nxt;
  logic              r_err_timeout, w_err_timeout_nxt;

  logic              w_cpu_new;
  logic              w_cpu_avail;
  logic              w_cpu_wins;
  logic              w_cpu_done;
  logic              w_end;
  logic [7:0]        w_rd;

  // ROM writes (write with sram=0) never become pending: they are dropped at the strobe
  assign w_cpu_new   = cpu_req & ~r_cpu_pend & (cpu_rnw | cpu_sram);
  assign w_cpu_avail = r_cpu_pend | w_cpu_new;
  assign w_cpu_wins  = w_cpu_avail & (~bk_req | (r_last == OWN_BK));
  assign w_end       = mem_ack | (r_cnt == CNT_LAST);
  assign w_rd        = mem_ack ? mem_rdata : 8'hFF;

  // CPU request latch and overrun detection
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cpu_pend    <= 1'b0;
      r_cpu_addr    <= '0;
      r_cpu_rnw     <= 1'b0;
      r_cpu_sram    <= 1'b0;
      r_cpu_wdata   <= '0;
      r_err_overrun <= 1'b0;
    end else begin
      if (w_cpu_new) begin
        r_cpu_pend  <= 1'b1;
        r_cpu_addr  <= cpu_addr;
        r_cpu_rnw   <= cpu_rnw;
        r_cpu_sram  <= cpu_sram;
        r_cpu_wdata <= cpu_wdata;
      end else if (w_cpu_done) begin
        r_cpu_pend  <= 1'b0;
      end
      if (cpu_req && r_cpu_pend) r_err_overrun <= 1'b1;
    end
  end

  // Arbitration FSM: next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_owner_nxt       = r_owner;
    w_last_nxt        = r_last;
    w_cnt_nxt         = r_cnt;
    w_mem_req_nxt     = r_mem_req;
    w_mem_addr_nxt    = r_mem_addr;
    w_mem_rnw_nxt     = r_mem_rnw;
    w_mem_sram_nxt    = r_mem_sram;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_cpu_rdata_nxt   = r_cpu_rdata;
    w_bk_rdata_nxt    = r_bk_rdata;
    w_ld_ack_nxt      = 1'b0;
    w_bk_ack_nxt      = 1'b0;
    w_err_timeout_nxt = r_err_timeout;
    w_cpu_done        = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (ld_req || w_cpu_avail || bk_req) begin
          w_state_nxt   = S_BUSY;
          w_cnt_nxt     = '0;
          w_mem_req_nxt = 1'b1;
          if (ld_req) begin
            w_owner_nxt     = OWN_LD;
            w_mem_addr_nxt  = ld_addr;
            w_mem_rnw_nxt   = 1'b0;
            w_mem_sram_nxt  = 1'b0;
            w_mem_wdata_nxt = ld_wdata;
          end else if (w_cpu_wins) begin
            w_owner_nxt     = OWN_CPU;
            w_mem_addr_nxt  = r_cpu_pend ? r_cpu_addr  : cpu_addr;
            w_mem_rnw_nxt   = r_cpu_pend ? r_cpu_rnw   : cpu_rnw;
            w_mem_sram_nxt  = r_cpu_pend ? r_cpu_sram  : cpu_sram;
            w_mem_wdata_nxt = r_cpu_pend ? r_cpu_wdata : cpu_wdata;
          end else begin
            w_owner_nxt     = OWN_BK;
            w_mem_addr_nxt  = bk_addr;
            w_mem_rnw_nxt   = bk_rnw;
            w_mem_sram_nxt  = 1'b1;
            w_mem_wdata_nxt = bk_wdata;
          end
        end
      end
      S_BUSY: begin
        if (w_end) begin
          w_state_nxt   = S_IDLE;
          w_mem_req_nxt = 1'b0;
          if (!mem_ack) w_err_timeout_nxt = 1'b1;
          unique case (r_owner)
            OWN_CPU: begin
              if (r_mem_rnw) w_cpu_rdata_nxt = w_rd;
              w_cpu_done = 1'b1;
              w_last_nxt = OWN_CPU;
            end
            OWN_BK: begin
              if (r_mem_rnw) w_bk_rdata_nxt = w_rd;
              w_bk_ack_nxt = 1'b1;
              w_last_nxt   = OWN_BK;
            end
            default: w_ld_ack_nxt = 1'b1;
          endcase
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Arbitration FSM: state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_owner       <= OWN_CPU;
      r_last        <= OWN_BK;
      r_cnt         <= '0;
      r_mem_req     <= 1'b0;
      r_mem_addr    <= '0;
      r_mem_rnw     <= 1'b0;
      r_mem_sram    <= 1'b0;
      r_mem_wdata   <= '0;
      r_cpu_rdata   <= 8'hFF;
      r_bk_rdata    <= 8'hFF;
      r_ld_ack      <= 1'b0;
      r_bk_ack      <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_owner       <= w_owner_nxt;
      r_last        <= w_last_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mem_req     <= w_mem_req_nxt;
      r_mem_addr    <= w_mem_addr_nxt;
      r_mem_rnw     <= w_mem_rnw_nxt;
      r_mem_sram    <= w_mem_sram_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_cpu_rdata   <= w_cpu_rdata_nxt;
      r_bk_rdata    <= w_bk_rdata_nxt;
      r_ld_ack      <= w_ld_ack_nxt;
      r_bk_ack      <= w_bk_ack_nxt;
      r_err_timeout <= w_err_timeout_nxt;
    end
  end

  assign cpu_wait    = cpu_req | r_cpu_pend;
  assign cpu_rdata   = r_cpu_rdata;
  assign bk_rdata    = r_bk_rdata;
  assign ld_ack      = r_ld_ack;
  assign bk_ack      = r_bk_ack;
  assign mem_req     = r_mem_req;
  assign mem_addr    = r_mem_addr;
  assign mem_rnw     = r_mem_rnw;
  assign mem_sram    = r_mem_sram;
  assign mem_wdata   = r_mem_wdata;
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;

endmodule
